// File: rtl/ip_rx_stream_arb_if.sv
// Bundle of NUM_SRCS header/data source channels plus the single merged downstream channel.
// A transfer happens on any cycle where val and rdy are both high; a source holds val and its payload stable until then.
interface ip_rx_stream_arb_if #(
  parameter int DATA_WIDTH     = 512,
  parameter int NUM_SRCS       = 2,
  parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH/8),
  parameter int SRC_W          = $clog2(NUM_SRCS),
  parameter int IP_HDR_W       = 160,
  parameter int TS_W           = 64
);
  logic [NUM_SRCS-1:0]                     src_arb_rx_hdr_val;
  logic [NUM_SRCS-1:0]                     arb_src_rx_hdr_rdy;
  logic [NUM_SRCS-1:0][IP_HDR_W-1:0]       src_arb_rx_ip_hdr;
  logic [NUM_SRCS-1:0][TS_W-1:0]           src_arb_rx_timestamp;
  logic [NUM_SRCS-1:0]                     src_arb_rx_data_val;
  logic [NUM_SRCS-1:0]                     arb_src_rx_data_rdy;
  logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]     src_arb_rx_data;
  logic [NUM_SRCS-1:0]                     src_arb_rx_last;
  logic [NUM_SRCS-1:0][PADBYTES_WIDTH-1:0] src_arb_rx_padbytes;

  logic                      arb_dst_rx_hdr_val;
  logic                      dst_arb_rx_hdr_rdy;
  logic [IP_HDR_W-1:0]       arb_dst_rx_ip_hdr;
  logic [TS_W-1:0]           arb_dst_rx_timestamp;
  logic                      arb_dst_rx_data_val;
  logic                      dst_arb_rx_data_rdy;
  logic [DATA_WIDTH-1:0]     arb_dst_rx_data;
  logic                      arb_dst_rx_last;
  logic [PADBYTES_WIDTH-1:0] arb_dst_rx_padbytes;
  logic [SRC_W-1:0]          arb_dst_rx_src;

  // Arbiter side.
  modport slave (
    input  src_arb_rx_hdr_val, src_arb_rx_ip_hdr, src_arb_rx_timestamp,
    input  src_arb_rx_data_val, src_arb_rx_data, src_arb_rx_last, src_arb_rx_padbytes,
    input  dst_arb_rx_hdr_rdy, dst_arb_rx_data_rdy,
    output arb_src_rx_hdr_rdy, arb_src_rx_data_rdy,
    output arb_dst_rx_hdr_val, arb_dst_rx_ip_hdr, arb_dst_rx_timestamp,
    output arb_dst_rx_data_val, arb_dst_rx_data, arb_dst_rx_last, arb_dst_rx_padbytes,
    output arb_dst_rx_src
  );

  // Environment side: sources and downstream consumer.
  modport master (
    output src_arb_rx_hdr_val, src_arb_rx_ip_hdr, src_arb_rx_timestamp,
    output src_arb_rx_data_val, src_arb_rx_data, src_arb_rx_last, src_arb_rx_padbytes,
    output dst_arb_rx_hdr_rdy, dst_arb_rx_data_rdy,
    input  arb_src_rx_hdr_rdy, arb_src_rx_data_rdy,
    input  arb_dst_rx_hdr_val, arb_dst_rx_ip_hdr, arb_dst_rx_timestamp,
    input  arb_dst_rx_data_val, arb_dst_rx_data, arb_dst_rx_last, arb_dst_rx_padbytes,
    input  arb_dst_rx_src
  );
endinterface

// File: rtl/ip_rx_stream_arb.sv
// Packet-granular round-robin merge of NUM_SRCS IP RX header/data streams onto one consumer.
// Zero-latency muxing; the grant is held from header accept until the last payload beat.
module ip_rx_stream_arb #(
  parameter int DATA_WIDTH     = 512,
  parameter int NUM_SRCS       = 2,
  parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH/8),
  parameter int SRC_W          = $clog2(NUM_SRCS),
  parameter int IP_HDR_W       = 160,
  parameter int TS_W           = 64
) (
  input  logic             clk,
  input  logic             rst,
  ip_rx_stream_arb_if.slave bus,
  output logic [1:0]       dbg_state_o,
  output logic [SRC_W-1:0] dbg_prio_o,
  output logic [SRC_W-1:0] dbg_grant_o
);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HDR_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRCS - 1);

  logic [1:0]       state_q, state_d;
  logic [SRC_W-1:0] prio_q, prio_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] grant, rr_idx, sel;
  logic             any_hdr, hdr_val, hdr_fire, last_fire;

  // Scan from the highest offset down so the lowest offset from prio_q wins.
  always_comb begin
    grant  = prio_q;
    rr_idx = prio_q;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      rr_idx = SRC_W'((int'(prio_q) + k) % NUM_SRCS);
      if (bus.src_arb_rx_hdr_val[rr_idx]) grant = rr_idx;
    end
  end

  assign any_hdr = |bus.src_arb_rx_hdr_val;
  // Once a header is presented, HDR_WAIT pins it to grant_q so it cannot change under valid.
  assign sel     = (state_q == ST_IDLE) ? grant : grant_q;

  always_comb begin
    hdr_val                  = 1'b0;
    bus.arb_src_rx_hdr_rdy   = '0;
    bus.arb_src_rx_data_rdy  = '0;
    bus.arb_dst_rx_data_val  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hdr_val                     = any_hdr;
        bus.arb_src_rx_hdr_rdy[sel] = bus.dst_arb_rx_hdr_rdy;
      end
      ST_HDR_WAIT: begin
        hdr_val                         = bus.src_arb_rx_hdr_val[grant_q];
        bus.arb_src_rx_hdr_rdy[grant_q] = bus.dst_arb_rx_hdr_rdy;
      end
      ST_DATA: begin
        bus.arb_dst_rx_data_val          = bus.src_arb_rx_data_val[grant_q];
        bus.arb_src_rx_data_rdy[grant_q] = bus.dst_arb_rx_data_rdy;
      end
      default: ;
    endcase
    if (rst) begin
      bus.arb_src_rx_hdr_rdy  = '0;
      bus.arb_src_rx_data_rdy = '0;
      bus.arb_dst_rx_data_val = 1'b0;
    end
  end

  assign bus.arb_dst_rx_hdr_val   = hdr_val;
  assign bus.arb_dst_rx_ip_hdr    = bus.src_arb_rx_ip_hdr[sel];
  assign bus.arb_dst_rx_timestamp = bus.src_arb_rx_timestamp[sel];
  assign bus.arb_dst_rx_src       = sel;
  assign bus.arb_dst_rx_data      = bus.src_arb_rx_data[grant_q];
  assign bus.arb_dst_rx_last      = bus.src_arb_rx_last[grant_q];
  assign bus.arb_dst_rx_padbytes  = bus.src_arb_rx_padbytes[grant_q];

  assign hdr_fire  = hdr_val & bus.dst_arb_rx_hdr_rdy;
  assign last_fire = bus.arb_dst_rx_data_val & bus.dst_arb_rx_data_rdy & bus.arb_dst_rx_last;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_hdr) begin
          grant_d = grant;
          state_d = bus.dst_arb_rx_hdr_rdy ? ST_DATA : ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: if (hdr_fire) state_d = ST_DATA;
      ST_DATA: begin
        if (last_fire) begin
          state_d = ST_IDLE;
          prio_d  = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_prio_o  = prio_q;
  assign dbg_grant_o = grant_q;
endmodule

// File: tb/tb_ip_rx_stream_arb.sv
// Directed bench for ip_rx_stream_arb: behavioural sources, always-checked downstream beat scoreboard.
module tb_ip_rx_stream_arb;
  localparam int DW = 64;
  localparam int NS = 2;
  localparam int PW = 3;
  localparam int SW = 1;
  localparam int HW = 32;
  localparam int TW = 16;
  localparam int BW = SW + 1 + PW + DW;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk;
  logic          rst;
  logic [1:0]    dbg_state;
  logic [SW-1:0] dbg_prio;
  logic [SW-1:0] dbg_grant;

  ip_rx_stream_arb_if #(.DATA_WIDTH(DW), .NUM_SRCS(NS), .PADBYTES_WIDTH(PW), .SRC_W(SW),
                        .IP_HDR_W(HW), .TS_W(TW)) bus ();

  ip_rx_stream_arb #(.DATA_WIDTH(DW), .NUM_SRCS(NS), .PADBYTES_WIDTH(PW), .SRC_W(SW),
                     .IP_HDR_W(HW), .TS_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_prio_o  (dbg_prio),
    .dbg_grant_o (dbg_grant)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [BW-1:0] exp_q[$];
  int acc_cyc[$];
  int acc_src[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int s, input int b);
    return 64'hD0D0_0000_0000_0000 | (64'(s) << 8) | 64'(b);
  endfunction
  function automatic logic [HW-1:0] hdr_of(input int s);
    return 32'hC0A8_0000 + 32'(s);
  endfunction
  function automatic logic [TW-1:0] ts_of(input int s);
    return 16'h7700 + 16'(s);
  endfunction
  function automatic logic [BW-1:0] exp_beat(input int s, input int b, input bit l, input int p);
    return {SW'(s), l, PW'(p), mk(s, b)};
  endfunction

  // ---------------- source model ----------------
  int npk[NS];
  int len[NS];
  int pad[NS];
  int beat[NS];
  bit in_hdr[NS];

  always_comb begin
    bus.src_arb_rx_hdr_val   = '0;
    bus.src_arb_rx_data_val  = '0;
    bus.src_arb_rx_last      = '0;
    bus.src_arb_rx_ip_hdr    = '0;
    bus.src_arb_rx_timestamp = '0;
    bus.src_arb_rx_data      = '0;
    bus.src_arb_rx_padbytes  = '0;
    for (int s = 0; s < NS; s++) begin
      bus.src_arb_rx_hdr_val[s]   = (npk[s] > 0) && in_hdr[s];
      bus.src_arb_rx_data_val[s]  = (npk[s] > 0) && !in_hdr[s];
      bus.src_arb_rx_last[s]      = (beat[s] == len[s] - 1);
      bus.src_arb_rx_ip_hdr[s]    = hdr_of(s);
      bus.src_arb_rx_timestamp[s] = ts_of(s);
      bus.src_arb_rx_data[s]      = mk(s, beat[s]);
      bus.src_arb_rx_padbytes[s]  = (beat[s] == len[s] - 1) ? PW'(pad[s]) : '0;
    end
  end

  always @(posedge clk) begin
    logic [NS-1:0] hf, df;
    logic r;
    hf = bus.src_arb_rx_hdr_val & bus.arb_src_rx_hdr_rdy;
    df = bus.src_arb_rx_data_val & bus.arb_src_rx_data_rdy;
    r  = rst;
    #1;
    for (int s = 0; s < NS; s++) begin
      if (r) begin
        in_hdr[s] = 1'b1;
        beat[s]   = 0;
      end else begin
        if (hf[s]) in_hdr[s] = 1'b0;
        if (df[s]) begin
          if (beat[s] == len[s] - 1) begin
            beat[s]   = 0;
            in_hdr[s] = 1'b1;
            npk[s]    = npk[s] - 1;
          end else begin
            beat[s] = beat[s] + 1;
          end
        end
      end
    end
  end

  // ---------------- downstream monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [BW-1:0] e;
    cyc++;
    if (!rst) begin
      if (bus.arb_dst_rx_hdr_val && bus.dst_arb_rx_hdr_rdy) begin
        acc_cyc.push_back(cyc);
        acc_src.push_back(int'(bus.arb_dst_rx_src));
        chk("hdr_ip", bus.arb_dst_rx_ip_hdr, hdr_of(int'(bus.arb_dst_rx_src)));
        chk("hdr_ts", bus.arb_dst_rx_timestamp, ts_of(int'(bus.arb_dst_rx_src)));
      end
      if (bus.arb_dst_rx_data_val && bus.dst_arb_rx_data_rdy) begin
        if (exp_q.size() == 0) begin
          chk("data_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_beat", {bus.arb_dst_rx_src, bus.arb_dst_rx_last,
                            bus.arb_dst_rx_padbytes, bus.arb_dst_rx_data}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      done = (npk[0] == 0) && (npk[1] == 0) && (dbg_state == ST_IDLE);
    end
    if (!done) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic chk_order(input string tag, input int a, input int b);
    chk({tag, "_count"}, acc_src.size(), 2);
    if (acc_src.size() == 2) begin
      chk({tag, "_first"}, acc_src[0], a);
      chk({tag, "_second"}, acc_src[1], b);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.dst_arb_rx_hdr_rdy  = 1'b1;
    bus.dst_arb_rx_data_rdy = 1'b1;
    for (int s = 0; s < NS; s++) begin
      in_hdr[s] = 1'b1; beat[s] = 0; len[s] = 2; pad[s] = 0; npk[s] = 2;
    end

    // Reset with every source requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_hdr_rdy", bus.arb_src_rx_hdr_rdy, 2'b00);
      chk("rst_data_rdy", bus.arb_src_rx_data_rdy, 2'b00);
      chk("rst_data_val", bus.arb_dst_rx_data_val, 0);
    end
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < 2; b++) exp_q.push_back(exp_beat(s, b, b == 1, 0));
    rst = 1'b0;
    #1;
    chk("post_rst_hdr_val", bus.arb_dst_rx_hdr_val, 1);
    chk("post_rst_src", bus.arb_dst_rx_src, 0);
    chk("post_rst_hdr_rdy", bus.arb_src_rx_hdr_rdy, 2'b01);

    // Contention: 2 packets each of 2 beats, alternating grant, accepts 3 cycles apart.
    wait_done(40);
    chk("cont_count", acc_src.size(), 4);
    if (acc_src.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("cont_order", acc_src[i], i % 2);
      for (int i = 0; i < 3; i++) chk("cont_spacing", acc_cyc[i+1] - acc_cyc[i], 3);
    end
    chk("cont_prio", dbg_prio, 0);
    acc_src.delete(); acc_cyc.delete();

    // Single source: src1, 3 beats, padbytes 5 on last.
    len[1] = 3; pad[1] = 5; npk[1] = 1;
    exp_q.push_back(exp_beat(1, 0, 0, 0));
    exp_q.push_back(exp_beat(1, 1, 0, 0));
    exp_q.push_back(exp_beat(1, 2, 1, 5));
    #1;
    chk("single_src", bus.arb_dst_rx_src, 1);
    chk("single_hdr_rdy", bus.arb_src_rx_hdr_rdy, 2'b10);
    wait_done(20);
    chk("single_count", acc_src.size(), 1);
    chk("single_prio", dbg_prio, 0);
    acc_src.delete(); acc_cyc.delete();

    // Header backpressure: header stays on src0 while src1 joins.
    bus.dst_arb_rx_hdr_rdy = 1'b0;
    len[0] = 1; len[1] = 1; pad[0] = 0; pad[1] = 0; npk[0] = 1;
    exp_q.push_back(exp_beat(0, 0, 1, 0));
    exp_q.push_back(exp_beat(1, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 1) npk[1] = 1;
      #1;
      chk("bp_hdr_val", bus.arb_dst_rx_hdr_val, 1);
      chk("bp_src", bus.arb_dst_rx_src, 0);
      chk("bp_ip_hdr", bus.arb_dst_rx_ip_hdr, hdr_of(0));
      chk("bp_hdr_rdy", bus.arb_src_rx_hdr_rdy, 2'b00);
      tick();
    end
    bus.dst_arb_rx_hdr_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", bus.arb_src_rx_hdr_rdy, 2'b01);
    chk("bp_release_src", bus.arb_dst_rx_src, 0);
    wait_done(20);
    chk_order("bp_order", 0, 1);
    acc_src.delete(); acc_cyc.delete();

    // Mid-packet request: src1 arrives while src0 streams 5 beats with a stall.
    len[0] = 5; pad[0] = 2; len[1] = 1; pad[1] = 3; npk[0] = 1;
    for (int b = 0; b < 5; b++) exp_q.push_back(exp_beat(0, b, b == 4, (b == 4) ? 2 : 0));
    exp_q.push_back(exp_beat(1, 0, 1, 3));
    #1;
    chk("mid_hdr_rdy0", bus.arb_src_rx_hdr_rdy, 2'b01);
    tick();
    for (int c = 1; c <= 6; c++) begin
      bus.dst_arb_rx_data_rdy = (c != 2);
      if (c == 2) npk[1] = 1;
      #1;
      chk("mid_hdr_rdy1", bus.arb_src_rx_hdr_rdy[1], 0);
      if (c == 2) chk("mid_stall_rdy", bus.arb_src_rx_data_rdy, 2'b00);
      tick();
    end
    #1;
    chk("mid_gap_idle", dbg_state, ST_IDLE);
    chk("mid_next_rdy", bus.arb_src_rx_hdr_rdy, 2'b10);
    chk("mid_next_src", bus.arb_dst_rx_src, 1);
    wait_done(20);
    chk_order("mid_order", 0, 1);
    acc_src.delete(); acc_cyc.delete();

    // Reset mid-packet: first move prio away from 0.
    len[0] = 1; pad[0] = 0; npk[0] = 1;
    exp_q.push_back(exp_beat(0, 0, 1, 0));
    wait_done(10);
    chk("prio_after_src0", dbg_prio, 1);
    len[0] = 4; npk[0] = 1;
    exp_q.push_back(exp_beat(0, 0, 0, 0));
    tick();
    tick();
    rst = 1'b1;
    npk[0] = 0;
    tick();
    #1;
    chk("rstmid_state", dbg_state, ST_IDLE);
    chk("rstmid_prio", dbg_prio, 0);
    chk("rstmid_hdr_rdy", bus.arb_src_rx_hdr_rdy, 2'b00);
    chk("rstmid_data_rdy", bus.arb_src_rx_data_rdy, 2'b00);
    chk("rstmid_data_val", bus.arb_dst_rx_data_val, 0);
    rst = 1'b0;
    tick();
    chk("scoreboard_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ip_rx_stream_arb.md
# ip_rx_stream_arb

Round-robin arbiter that merges NUM_SRCS independent IP RX streams onto one downstream IP consumer. Each stream is a header/data channel pair of the form produced by the IP stream formatting pipeline: a header beat carrying the IP header and timestamp, followed by a realigned payload ending in `last`. The block grants one source per packet and keeps that header and its complete payload together, with no interleaving. It sits between the per-port IP format pipes and the shared TCP/UDP RX demux.

## Interface
- DATA_WIDTH, default 512: payload beat width in bits.
- NUM_SRCS, default 2: number of requesting streams; valid range ≥2.
- PADBYTES_WIDTH, default $clog2(DATA_WIDTH/8): width of the padbytes field.
- SRC_W, default $clog2(NUM_SRCS): width of the grant index.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, synchronous, active-high.
- src_arb_rx_hdr_val  in  NUM_SRCS: header valid, one bit per source.
- arb_src_rx_hdr_rdy  out  NUM_SRCS: header ready, one bit per source.
- src_arb_rx_ip_hdr  in  NUM_SRCS×IP_HDR_W: per-source ip_pkt_hdr.
- src_arb_rx_timestamp  in  NUM_SRCS×tracker_stats_struct: per-source timestamp.
- src_arb_rx_data_val  in  NUM_SRCS: payload valid.
- arb_src_rx_data_rdy  out  NUM_SRCS: payload ready.
- src_arb_rx_data  in  NUM_SRCS×DATA_WIDTH: payload beat.
- src_arb_rx_last  in  NUM_SRCS: last beat of the packet.
- src_arb_rx_padbytes  in  NUM_SRCS×PADBYTES_WIDTH: invalid trailing bytes on the last beat.
- arb_dst_rx_hdr_val  out  1: downstream header valid.
- dst_arb_rx_hdr_rdy  in  1: downstream header ready.
- arb_dst_rx_ip_hdr  out  IP_HDR_W: header of the granted source.
- arb_dst_rx_timestamp  out  tracker_stats_struct: timestamp of the granted source.
- arb_dst_rx_data_val  out  1: downstream payload valid.
- dst_arb_rx_data_rdy  in  1: downstream payload ready.
- arb_dst_rx_data  out  DATA_WIDTH: payload beat.
- arb_dst_rx_last  out  1: last beat.
- arb_dst_rx_padbytes  out  PADBYTES_WIDTH: padbytes of the granted source.
- arb_dst_rx_src  out  SRC_W: index of the granted source; valid with both header and data.

## Operation
- Every accepted header is followed by exactly one payload stream from the same source, terminated by `last`. Sources guarantee this pairing.
- The FSM has three states: IDLE, HDR_WAIT and DATA.
- The round-robin pointer `prio_reg` (SRC_W bits) names the highest-priority source. Reset value is 0.
- **Grant selection, IDLE:** grant is the first index i with src_arb_rx_hdr_val[i] set, scanning from prio_reg upward and wrapping modulo NUM_SRCS.
- **IDLE behaviour:**
  - arb_dst_rx_hdr_val = |src_arb_rx_hdr_val.
  - Header, timestamp and src are muxed from the combinational grant.
  - arb_src_rx_hdr_rdy[grant] = dst_arb_rx_hdr_rdy; all other ready bits are 0.
  - grant_reg ← grant whenever any header valid is set.
  - Header accepted → DATA. Header valid but not accepted → HDR_WAIT.
- **HDR_WAIT:** presents the header of grant_reg only, regardless of new requests, so a presented header never changes while valid is high. On accept → DATA.
- **DATA:**
  - arb_dst_rx_data_val = src_arb_rx_data_val[grant_reg].
  - data, last and padbytes are muxed from grant_reg.
  - arb_src_rx_data_rdy[grant_reg] = dst_arb_rx_data_rdy; all other data ready bits are 0.
  - arb_dst_rx_hdr_val = 0.
  - A beat with val, rdy and last all set → IDLE, and prio_reg ← (grant_reg+1) mod NUM_SRCS. The pointer uses explicit wrap, not power-of-two truncation.
- Data ready is 0 for every source in IDLE and HDR_WAIT.
- Header ready is 0 for every source in DATA. Headers from any source arriving mid-packet wait.
- Payload padbytes and last are passed through unmodified. The block performs no checksum or length checks.

## Timing
- **Reset:** state = IDLE, prio_reg = 0, grant_reg = 0.
  - All *_rdy outputs = 0 and arb_dst_rx_data_val = 0.
  - arb_dst_rx_hdr_val follows the inputs combinationally from the first cycle after reset.
- **Latency:** header and data paths are zero-latency combinational passthroughs; there are no internal buffers.
- **Packet boundary:** the cycle after the last beat is accepted is always IDLE. This gives a minimum one-cycle gap between a packet's last beat and the next header accept.
- **Throughput:** a single-beat packet occupies at least 2 cycles (header accept, then data beat).
- **Simultaneous header valids:** resolved purely by prio_reg. The same source is never granted twice in a row while another source is requesting.
- **Reset mid-packet:** returns to IDLE immediately. Any partially transferred packet is abandoned; sources are reset alongside.
- **rdy/val independence:** no output rdy depends on a downstream val, so there are no combinational loops. Valid is never withdrawn by the arbiter while in HDR_WAIT.

## Test plan
- **Reset:** assert rst for 3 cycles with all src valids high → all rdy outputs 0 and data_val 0; hdr_val = 1 on the first post-reset cycle with src = 0.
- **Single source:** src1 sends header plus 3 beats (last beat padbytes = 5), dst always ready → dst sees src = 1, 3 data beats with last on beat 3 and padbytes = 5; prio_reg = 0 afterwards.
- **Contention:** src0 and src1 both request continuously with 2-beat packets → grant order 0,1,0,1; hdr accepts spaced exactly 3 cycles apart.
- **Header backpressure:** dst_hdr_rdy held low for 4 cycles while src0 is granted and src1 raises valid in cycle 2 → header and src stay at src0 for all 4 cycles; src0 is accepted when rdy rises.
- **Mid-packet request:** src1 header valid arrives during src0 beat 2 of 5, with dst_data_rdy toggling 1,0,1 → arb_src_rx_hdr_rdy[1] stays 0 until src0's last beat; no beats are lost or duplicated.
- **Reset mid-packet:** assert rst during beat 2 of a 4-beat packet → next cycle is IDLE with prio_reg = 0 and all rdy outputs = 0.
